// File: rtl/ic_hc_codebook_lut.sv
// Run-time loadable multi-table Huffman codebook.
// One shared RAM holds NUM_TABLES tables of DEPTH entries, each entry {len, code}.
// After reset or tbl_clear a sequencer zero-fills the RAM; the host then loads tables
// through the cfg port while lookups flow through a 2-stage valid/ready pipeline.
module ic_hc_codebook_lut #(
   parameter int unsigned NUM_TABLES  = 4,
   parameter int unsigned DEPTH       = 16,
   parameter int unsigned NUM_SYMBOLS = 12,
   parameter int unsigned CODE_W      = 16,
   parameter int unsigned LEN_W       = 5,
   localparam int unsigned ADDR_W     = $clog2(DEPTH),
   localparam int unsigned TBL_W      = (NUM_TABLES > 1) ? $clog2(NUM_TABLES) : 1
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              tbl_clear,
   output logic              init_done,
   input  logic              cfg_we,
   input  logic [TBL_W-1:0]  cfg_table,
   input  logic [ADDR_W-1:0] cfg_addr,
   input  logic [LEN_W-1:0]  cfg_len,
   input  logic [CODE_W-1:0] cfg_code,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [TBL_W-1:0]  in_table,
   input  logic [ADDR_W-1:0] in_symbol,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CODE_W-1:0] out_code,
   output logic [LEN_W-1:0]  out_len,
   output logic              out_err
);

   localparam int unsigned ENTRY_W = LEN_W + CODE_W;
   localparam int unsigned MEM_AW  = TBL_W + ADDR_W;
   localparam int unsigned ENTRIES = NUM_TABLES * DEPTH;

   localparam logic [0:0] StInit = 1'b0;
   localparam logic [0:0] StRun  = 1'b1;

   logic [0:0]         state_q, state_d;
   logic [MEM_AW-1:0]  cnt_q, cnt_d;

   logic [ENTRY_W-1:0] mem [ENTRIES];
   logic [ENTRY_W-1:0] rd_q;

   logic               mem_we;
   logic [MEM_AW-1:0]  mem_waddr;
   logic [ENTRY_W-1:0] mem_wdata;
   logic [MEM_AW-1:0]  mem_raddr;

   logic               cfg_tbl_ok;
   logic               in_tbl_ok;
   logic               in_err;
   logic               adv;
   logic               accept;

   logic               s1_valid_q;
   logic               s1_err_q;

   logic [CODE_W-1:0]  rd_code;
   logic [LEN_W-1:0]   rd_len;

   assign init_done  = (state_q == StRun);
   // Both stages move together; a full output stage with no taker freezes the pipe.
   assign adv        = ~out_valid | out_ready;
   assign in_ready   = init_done & adv;
   assign accept     = in_valid & in_ready;

   assign cfg_tbl_ok = (32'(cfg_table) < NUM_TABLES);
   assign in_tbl_ok  = (32'(in_table) < NUM_TABLES);
   assign in_err     = (32'(in_symbol) >= NUM_SYMBOLS) | ~in_tbl_ok;

   assign rd_len     = rd_q[ENTRY_W-1:CODE_W];
   assign rd_code    = rd_q[CODE_W-1:0];

   // Next-state logic for the zero-fill sequencer and run mode.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (tbl_clear) begin
         state_d = StInit;
         cnt_d   = '0;
      end else if (state_q == StInit) begin
         if (cnt_q == MEM_AW'(ENTRIES - 1)) begin
            state_d = StRun;
            cnt_d   = '0;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // Sequencer state and zero-fill counter.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StInit;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Single write port is shared between the zero-fill and host loads.
   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = '0;
      mem_wdata = '0;
      if (state_q == StInit) begin
         mem_we    = 1'b1;
         mem_waddr = cnt_q;
      end else if (cfg_we && cfg_tbl_ok) begin
         mem_we    = 1'b1;
         mem_waddr = {cfg_table, cfg_addr};
         mem_wdata = {cfg_len, cfg_code};
      end
      // Out-of-range tables read a harmless entry; the error flag covers the result.
      mem_raddr = in_tbl_ok ? {in_table, in_symbol} : '0;
   end

   // RAM write and stage-1 synchronous read; a same-cycle write is seen as old data.
   always_ff @(posedge clock) begin
      if (mem_we) begin
         mem[mem_waddr] <= mem_wdata;
      end
      if (accept) begin
         rd_q <= mem[mem_raddr];
      end
   end

   // Stage-1 control: valid and range error travel alongside the RAM read.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         s1_valid_q <= 1'b0;
         s1_err_q   <= 1'b0;
      end else if (tbl_clear) begin
         s1_valid_q <= 1'b0;
      end else if (adv) begin
         s1_valid_q <= accept;
         if (accept) begin
            s1_err_q <= in_err;
         end
      end
   end

   // Stage-2 output registers; held while the consumer stalls.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         out_valid <= 1'b0;
         out_code  <= '0;
         out_len   <= '0;
         out_err   <= 1'b0;
      end else if (tbl_clear) begin
         out_valid <= 1'b0;
      end else if (adv) begin
         out_valid <= s1_valid_q;
         if (s1_valid_q) begin
            out_code <= s1_err_q ? '0 : rd_code;
            out_len  <= s1_err_q ? '0 : rd_len;
            out_err  <= s1_err_q | (rd_len == '0);
         end
      end
   end

endmodule

// File: tb/tb_ic_hc_codebook_lut.sv
// Self-checking bench for ic_hc_codebook_lut: a table model plus in-order result queues.
module tb_ic_hc_codebook_lut;

   localparam int NT = 4;
   localparam int DEP = 16;
   localparam int NSYM = 12;
   localparam int ENTRIES = NT * DEP;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        tbl_clear = 1'b0;
   logic        init_done;
   logic        cfg_we = 1'b0;
   logic [1:0]  cfg_table = '0;
   logic [3:0]  cfg_addr = '0;
   logic [4:0]  cfg_len = '0;
   logic [15:0] cfg_code = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [1:0]  in_table = '0;
   logic [3:0]  in_symbol = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [15:0] out_code;
   logic [4:0]  out_len;
   logic        out_err;

   typedef struct {
      logic [15:0] code;
      logic [4:0]  len;
      logic        err;
      int          cyc;
   } res_t;

   res_t        exp_q[$];
   res_t        got_q[$];
   logic [20:0] model [NT][DEP];
   int          cyc = 0;
   int          n_tests = 0;
   int          n_fail = 0;

   always #5 clock = ~clock;

   ic_hc_codebook_lut #(
      .NUM_TABLES (NT),
      .DEPTH      (DEP),
      .NUM_SYMBOLS(NSYM),
      .CODE_W     (16),
      .LEN_W      (5)
   ) dut (
      .clock    (clock),
      .reset_n  (reset_n),
      .tbl_clear(tbl_clear),
      .init_done(init_done),
      .cfg_we   (cfg_we),
      .cfg_table(cfg_table),
      .cfg_addr (cfg_addr),
      .cfg_len  (cfg_len),
      .cfg_code (cfg_code),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_table (in_table),
      .in_symbol(in_symbol),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_code (out_code),
      .out_len  (out_len),
      .out_err  (out_err)
   );

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
      $fatal(1);
   end

   task automatic model_zero();
      for (int t = 0; t < NT; t++)
         for (int a = 0; a < DEP; a++) model[t][a] = '0;
   endtask

   task automatic flush();
      exp_q.delete();
      got_q.delete();
   endtask

   // One clock: predicts accepted lookups from the model, records fired outputs.
   task automatic cycle(output bit acc);
      bit fire, clr, wr;
      res_t e, g;
      logic [20:0] ent;
      #1;
      acc  = in_valid && in_ready;
      fire = out_valid && out_ready;
      clr  = tbl_clear;
      wr   = cfg_we && init_done;
      e = '{code: 16'h0, len: 5'h0, err: 1'b1, cyc: 0};
      if (acc && in_symbol < NSYM) begin
         ent = model[in_table][in_symbol];
         e.len  = ent[20:16];
         e.code = ent[15:0];
         e.err  = (ent[20:16] == 5'd0);
      end
      g = '{code: out_code, len: out_len, err: out_err, cyc: 0};
      @(posedge clock);
      #1;
      cyc++;
      if (fire) begin
         g.cyc = cyc;
         got_q.push_back(g);
      end
      if (clr) begin
         while (exp_q.size() > got_q.size()) void'(exp_q.pop_back());
         model_zero();
      end else begin
         if (acc) begin
            e.cyc = cyc;
            exp_q.push_back(e);
         end
         if (wr) model[cfg_table][cfg_addr] = {cfg_len, cfg_code};
      end
   endtask

   task automatic drain();
      bit a;
      in_valid  = 1'b0;
      cfg_we    = 1'b0;
      tbl_clear = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 30 && exp_q.size() > got_q.size(); i++) cycle(a);
   endtask

   task automatic wait_init(output int n);
      bit a;
      n = 0;
      while (!init_done && n < 300) begin
         cycle(a);
         n++;
      end
   endtask

   task automatic write_entry(input int t, input int ad, input int l, input int c);
      bit a;
      in_valid  = 1'b0;
      cfg_we    = 1'b1;
      cfg_table = 2'(t);
      cfg_addr  = 4'(ad);
      cfg_len   = 5'(l);
      cfg_code  = 16'(c);
      cycle(a);
      cfg_we = 1'b0;
   endtask

   task automatic issue(input int t, input int s);
      bit a;
      in_valid  = 1'b1;
      in_table  = 2'(t);
      in_symbol = 4'(s);
      for (int i = 0; i < 50; i++) begin
         cycle(a);
         if (a) break;
      end
   endtask

   task automatic test_reset();
      int n;
      bit early;
      reset_n = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      n_tests++;
      if ({out_valid, init_done, in_ready, out_err} !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_flags: got %b required 0000",
                  {out_valid, init_done, in_ready, out_err});
      end
      n_tests++;
      if ({out_len, out_code} !== 21'h0) begin
         n_fail++;
         $display("FAIL reset_data: got %h required 0", {out_len, out_code});
      end
      reset_n = 1'b1;
      flush();
      model_zero();
      early = 0;
      n = 0;
      while (!init_done && n < 300) begin
         bit a;
         in_valid = 1'b1;
         cycle(a);
         if (a) early = 1;
         n++;
      end
      in_valid = 1'b0;
      n_tests++;
      if (n !== ENTRIES) begin
         n_fail++;
         $display("FAIL reset_init_cycles: got %0d required %0d", n, ENTRIES);
      end
      n_tests++;
      if (early !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_in_ready_early: got accept during init, required none");
      end
      flush();
      for (int i = 0; i < 4; i++) issue($urandom_range(0, NT - 1), $urandom_range(0, DEP - 1));
      drain();
      n_tests++;
      if (got_q.size() !== 4) begin
         n_fail++;
         $display("FAIL reset_lookup_count: got %0d required 4", got_q.size());
      end
      foreach (got_q[i]) begin
         n_tests++;
         if ({got_q[i].len, got_q[i].err} !== {5'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_lookup_%0d: got len %0d err %b required len 0 err 1",
                     i, got_q[i].len, got_q[i].err);
         end
      end
   endtask

   task automatic test_dc_c();
      logic [15:0] k_code [3];
      logic [4:0]  k_len [3];
      k_code = '{16'h0000, 16'h0001, 16'h07FE};
      k_len  = '{5'd2, 5'd2, 5'd11};
      write_entry(1, 0, 2, 'h0);
      write_entry(1, 1, 2, 'h1);
      write_entry(1, 11, 11, 'h7FE);
      flush();
      out_ready = 1'b1;
      issue(1, 0);
      issue(1, 1);
      issue(1, 11);
      drain();
      n_tests++;
      if (got_q.size() !== 3 || exp_q.size() !== 3) begin
         n_fail++;
         $display("FAIL dcc_count: got %0d required 3", got_q.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            n_tests++;
            if ({got_q[i].code, got_q[i].len, got_q[i].err} !== {k_code[i], k_len[i], 1'b0}) begin
               n_fail++;
               $display("FAIL dcc_result_%0d: got code %h len %0d err %b required code %h len %0d err 0",
                        i, got_q[i].code, got_q[i].len, got_q[i].err, k_code[i], k_len[i]);
            end
            // Accepted on edge N, result presented and taken by edge N+2.
            n_tests++;
            if (got_q[i].cyc - exp_q[i].cyc !== 2) begin
               n_fail++;
               $display("FAIL dcc_latency_%0d: got %0d required 2", i,
                        got_q[i].cyc - exp_q[i].cyc);
            end
         end
         n_tests++;
         if (got_q[2].cyc - got_q[0].cyc !== 2) begin
            n_fail++;
            $display("FAIL dcc_back_to_back: got span %0d required 2",
                     got_q[2].cyc - got_q[0].cyc);
         end
      end
   endtask

   task automatic test_backpressure();
      bit a;
      logic [21:0] held;
      for (int s = 0; s < NSYM; s++)
         write_entry(2, s, $urandom_range(1, 31), $urandom_range(0, 16'hFFFF));
      flush();
      held = '0;
      in_valid  = 1'b1;
      in_table  = 2'd2;
      in_symbol = 4'($urandom_range(0, NSYM - 1));
      for (int k = 0; k < 14; k++) begin
         out_ready = !(k >= 3 && k < 8);
         cycle(a);
         if (a) in_symbol = 4'($urandom_range(0, NSYM - 1));
         if (k == 3) held = {out_code, out_len, out_err};
         if (k >= 3 && k < 8) begin
            n_tests++;
            if ({in_ready, out_valid} !== 2'b01) begin
               n_fail++;
               $display("FAIL bp_stall_k%0d: got in_ready %b out_valid %b required 0 1",
                        k, in_ready, out_valid);
            end
         end
         if (k > 3 && k < 8) begin
            n_tests++;
            if ({out_code, out_len, out_err} !== held) begin
               n_fail++;
               $display("FAIL bp_hold_k%0d: got %h required %h", k,
                        {out_code, out_len, out_err}, held);
            end
         end
      end
      drain();
      n_tests++;
      if (got_q.size() !== exp_q.size()) begin
         n_fail++;
         $display("FAIL bp_count: got %0d required %0d", got_q.size(), exp_q.size());
      end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         n_tests++;
         if ({got_q[i].code, got_q[i].len, got_q[i].err} !==
             {exp_q[i].code, exp_q[i].len, exp_q[i].err}) begin
            n_fail++;
            $display("FAIL bp_order_%0d: got %h/%0d/%b required %h/%0d/%b", i,
                     got_q[i].code, got_q[i].len, got_q[i].err,
                     exp_q[i].code, exp_q[i].len, exp_q[i].err);
         end
      end
   endtask

   task automatic test_errors();
      bit a;
      flush();
      issue(0, 12);
      issue(1, 15);
      drain();
      n_tests++;
      if (got_q.size() !== 2) begin
         n_fail++;
         $display("FAIL err_count: got %0d required 2", got_q.size());
      end
      foreach (got_q[i]) begin
         n_tests++;
         if ({got_q[i].code, got_q[i].len, got_q[i].err} !== {16'h0, 5'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL err_range_%0d: got %h/%0d/%b required 0/0/1", i,
                     got_q[i].code, got_q[i].len, got_q[i].err);
         end
      end
      // Collision: write t1/sym1 and look it up on the same edge.
      flush();
      in_valid  = 1'b1;
      in_table  = 2'd1;
      in_symbol = 4'd1;
      cfg_we    = 1'b1;
      cfg_table = 2'd1;
      cfg_addr  = 4'd1;
      cfg_len   = 5'd3;
      cfg_code  = 16'h0005;
      cycle(a);
      cfg_we = 1'b0;
      n_tests++;
      if (a !== 1'b1) begin
         n_fail++;
         $display("FAIL collide_accept: got %b required 1", a);
      end
      issue(1, 1);
      drain();
      n_tests++;
      if (got_q.size() !== 2) begin
         n_fail++;
         $display("FAIL collide_count: got %0d required 2", got_q.size());
      end else begin
         n_tests++;
         if ({got_q[0].code, got_q[0].len} !== {16'h0001, 5'd2}) begin
            n_fail++;
            $display("FAIL collide_old: got code %h len %0d required 0001 len 2",
                     got_q[0].code, got_q[0].len);
         end
         n_tests++;
         if ({got_q[1].code, got_q[1].len} !== {16'h0005, 5'd3}) begin
            n_fail++;
            $display("FAIL collide_new: got code %h len %0d required 0005 len 3",
                     got_q[1].code, got_q[1].len);
         end
      end
   endtask

   task automatic test_random();
      bit a;
      flush();
      a = 0;
      in_valid = 1'b0;
      for (int k = 0; k < 300; k++) begin
         if (!in_valid || a) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_table  = 2'($urandom);
            in_symbol = 4'($urandom);
         end
         cfg_we    = ($urandom_range(0, 3) == 0);
         cfg_table = 2'($urandom);
         cfg_addr  = 4'($urandom);
         cfg_len   = 5'($urandom);
         cfg_code  = 16'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         cycle(a);
      end
      drain();
      n_tests++;
      if (got_q.size() !== exp_q.size()) begin
         n_fail++;
         $display("FAIL rand_count: got %0d required %0d", got_q.size(), exp_q.size());
      end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         n_tests++;
         if ({got_q[i].code, got_q[i].len, got_q[i].err} !==
             {exp_q[i].code, exp_q[i].len, exp_q[i].err}) begin
            n_fail++;
            $display("FAIL rand_%0d: got %h/%0d/%b required %h/%0d/%b", i,
                     got_q[i].code, got_q[i].len, got_q[i].err,
                     exp_q[i].code, exp_q[i].len, exp_q[i].err);
         end
      end
   endtask

   task automatic test_clear();
      bit a;
      int n;
      write_entry(1, 0, 2, 'h0);
      write_entry(1, 1, 2, 'h1);
      write_entry(1, 11, 11, 'h7FE);
      flush();
      out_ready = 1'b0;
      issue(1, 0);
      issue(1, 1);
      in_valid  = 1'b0;
      tbl_clear = 1'b1;
      cycle(a);
      tbl_clear = 1'b0;
      out_ready = 1'b1;
      n_tests++;
      if ({out_valid, init_done} !== 2'b00) begin
         n_fail++;
         $display("FAIL clear_flags: got out_valid %b init_done %b required 0 0",
                  out_valid, init_done);
      end
      wait_init(n);
      n_tests++;
      if (n !== ENTRIES) begin
         n_fail++;
         $display("FAIL clear_init_cycles: got %0d required %0d", n, ENTRIES);
      end
      n_tests++;
      if (got_q.size() !== 0) begin
         n_fail++;
         $display("FAIL clear_dropped: got %0d results required 0", got_q.size());
      end
      flush();
      issue(1, 0);
      issue(1, 1);
      issue(1, 11);
      drain();
      n_tests++;
      if (got_q.size() !== 3) begin
         n_fail++;
         $display("FAIL clear_lookup_count: got %0d required 3", got_q.size());
      end
      foreach (got_q[i]) begin
         n_tests++;
         if ({got_q[i].len, got_q[i].err} !== {5'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL clear_zeroed_%0d: got len %0d err %b required 0 1",
                     i, got_q[i].len, got_q[i].err);
         end
      end
   endtask

   task automatic test_async_reset();
      int n;
      write_entry(3, 5, 7, 'h55);
      flush();
      out_ready = 1'b1;
      issue(3, 5);
      issue(3, 5);
      issue(3, 5);
      n_tests++;
      if (out_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL areset_pre: got out_valid %b required 1", out_valid);
      end
      #2;
      in_valid = 1'b0;
      reset_n  = 1'b0;
      #1;
      n_tests++;
      if ({out_valid, init_done, in_ready} !== 3'b000) begin
         n_fail++;
         $display("FAIL areset_immediate: got %b required 000",
                  {out_valid, init_done, in_ready});
      end
      @(posedge clock);
      #1;
      reset_n = 1'b1;
      flush();
      model_zero();
      wait_init(n);
      n_tests++;
      if (n !== ENTRIES) begin
         n_fail++;
         $display("FAIL areset_init_cycles: got %0d required %0d", n, ENTRIES);
      end
      issue(3, 5);
      drain();
      n_tests++;
      if (got_q.size() !== 1) begin
         n_fail++;
         $display("FAIL areset_count: got %0d required 1", got_q.size());
      end else begin
         n_tests++;
         if ({got_q[0].len, got_q[0].err} !== {5'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL areset_zeroed: got len %0d err %b required 0 1",
                     got_q[0].len, got_q[0].err);
         end
      end
   endtask

   initial begin
      model_zero();
      test_reset();
      test_dc_c();
      test_backpressure();
      test_errors();
      test_random();
      test_clear();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
